write_buffer: RTL

//  Receives dirty cachelines evicted by the cache data RAM (push on wb_push_en).

---
 rtl/write_buffer_if.sv | 32 +++
 rtl/write_buffer.sv | 119 +++++++++++
 2 files changed

// File: rtl/write_buffer_if.sv
// Bundle of the write buffer's push, lookup and memory-write signals.
// The master side is the cache/memory environment; the slave side is the buffer itself.
interface write_buffer_if #(
  parameter int ADDR_WIDTH      = 32,
  parameter int CACHELINE_WIDTH = 128
);
  logic                       wb_push_en;
  logic [ADDR_WIDTH-1:0]      wb_push_addr;
  logic [CACHELINE_WIDTH-1:0] wb_push_data;
  logic                       wb_full;
  logic                       wb_empty;
  logic                       wb_overflow;
  logic [ADDR_WIDTH-1:0]      lookup_addr;
  logic                       lookup_hit;
  logic [CACHELINE_WIDTH-1:0] lookup_data;
  logic                       mem_wr_req;
  logic [ADDR_WIDTH-1:0]      mem_wr_addr;
  logic [CACHELINE_WIDTH-1:0] mem_wr_data;
  logic                       mem_wr_ack;

  modport master (
    output wb_push_en, wb_push_addr, wb_push_data, lookup_addr, mem_wr_ack,
    input  wb_full, wb_empty, wb_overflow, lookup_hit, lookup_data,
           mem_wr_req, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  wb_push_en, wb_push_addr, wb_push_data, lookup_addr, mem_wr_ack,
    output wb_full, wb_empty, wb_overflow, lookup_hit, lookup_data,
           mem_wr_req, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/write_buffer.sv
// Eviction write buffer: DEPTH-entry FIFO of dirty lines drained to memory over req/ack.
// Define WB_FORWARD_EN to build the lookup comparators that forward queued lines to the miss path.
module write_buffer #(
  parameter int ADDR_WIDTH      = 32,
  parameter int CACHELINE_WIDTH = 128,
  parameter int OFFSET_WIDTH    = 4,
  parameter int DEPTH           = 4
) (
  input  logic          clk,
  input  logic          rst,
  write_buffer_if.slave wb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~ADDR_WIDTH'((64'd1 << OFFSET_WIDTH) - 64'd1);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [ADDR_WIDTH-1:0]      r_addr [DEPTH];
  logic [CACHELINE_WIDTH-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]           r_wr_ptr;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic [CNT_W-1:0]           r_count;
  logic                       r_overflow;
  logic                       w_full;
  logic                       w_pop;
  logic                       w_push;
  logic                       w_drop;
  logic                       w_req;
  logic                       w_hit;
  logic [CACHELINE_WIDTH-1:0] w_hit_data;

  assign w_full = (r_count == CNT_W'(DEPTH));
  assign w_req  = (r_state == S_REQ);
  // A full buffer still accepts a push when the head leaves on the same edge.
  assign w_push = wb.wb_push_en && (!w_full || w_pop);
  assign w_drop = wb.wb_push_en && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= wb.wb_push_addr & LINE_MASK;
      r_data[r_wr_ptr] <= wb.wb_push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: if (r_count != '0) w_state_nxt = S_REQ;
      S_REQ: begin
        if (wb.mem_wr_ack) begin
          w_pop       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign wb.mem_wr_req  = w_req;
  assign wb.mem_wr_addr = w_req ? r_addr[r_rd_ptr] : '0;
  assign wb.mem_wr_data = w_req ? r_data[r_rd_ptr] : '0;
  assign wb.wb_full     = w_full;
  assign wb.wb_empty    = (r_count == '0);
  assign wb.wb_overflow = r_overflow;

`ifdef WB_FORWARD_EN
  logic [PTR_W-1:0] w_idx;

  // Walk oldest to youngest so the last match, the youngest copy, wins.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    w_idx      = r_rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < r_count) &&
          (r_addr[w_idx] == (wb.lookup_addr & LINE_MASK))) begin
        w_hit      = 1'b1;
        w_hit_data = r_data[w_idx];
      end
    end
  end
`else
  logic w_unused_lookup;

  assign w_unused_lookup = ^wb.lookup_addr;
  assign w_hit           = 1'b0;
  assign w_hit_data      = '0;
`endif

  assign wb.lookup_hit  = w_hit;
  assign wb.lookup_data = w_hit_data;
endmodule
